ahb_slave_memory_responder: RTL
===============================

Name: ahb_slave_memory_responder

Overview:
- AHB slave-side responder with SRAM-backed word storage.
- Attaches to one slave port of the AHB interconnect, on the slave-interface signal set.
- Accepts address phases, inserts a programmable number of wait states, and performs byte-lane-correct reads and writes.
- Returns the two-cycle ERROR response for illegal accesses; serves as the target model for interconnect arbitration and data-phase tests.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; only 32 is supported.
- MEM_DEPTH, 256, number of DATA_WIDTH words; must be a power of 2.
- WAIT_STATES, 0, hreadyout-low cycles inserted before each OKAY data-phase completion; range 0..15.
- BASE_MASK_BITS, 2, number of top haddr bits ignored in decode (slave-select bits).

Ports:
- hclk  input  1  AHB clock, all logic on rising edge.
- hreset  input  1  synchronous, active-high reset.
- hselx  input  1  slave select from interconnect.
- haddr  input  ADDR_WIDTH  address.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  input  1  1 = write.
- hsize  input  3  transfer size, 0 = byte, 1 = half, 2 = word.
- hburst  input  3  burst type; informational only.
- hprot  input  4  protection; ignored.
- hmastlock  input  1  lock; ignored.
- hwdata  input  DATA_WIDTH  write data, valid in the data phase.
- hready  input  1  bus-level ready; an address phase is sampled only when hready=1.
- hreadyout  output  1  slave ready.
- hresp  output  2  00 OKAY, 01 ERROR.
- hrdata  output  DATA_WIDTH  read data.

Behaviour:
- Reset (hreset=1 at a rising edge):
  - state=IDLE, hreadyout=1, hresp=00, hrdata=0, wait counter=0, pending-transfer registers cleared.
  - Memory contents are not cleared.
  - Reset mid-wait or mid-error aborts the transfer; no memory write occurs.
- Address-phase acceptance: hselx=1, hready=1 and htrans in {NONSEQ, SEQ} at a rising edge. On acceptance, register haddr, hwrite, hsize.
- IDLE or BUSY with hselx=1 and hready=1: no transfer is registered; the next cycle is an OKAY zero-wait response.
- Word index = haddr[log2(MEM_DEPTH)+1:2], taken after masking the top BASE_MASK_BITS.
- Illegal access, decided at acceptance:
  - hsize>2;
  - misalignment: hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0;
  - out of range: masked byte address >= MEM_DEPTH*4.
- State machine:
  - IDLE: hreadyout=1, hresp=00. On a legal accept with WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1. On a legal accept with WAIT_STATES=0, go to DATA. On an illegal accept, go to ERR1.
  - WAIT: hreadyout=0, hresp=00. Counter decrements each cycle; at 0, go to DATA.
  - DATA: hreadyout=1, hresp=00; the transfer completes at this edge.
    - Write: hwdata is sampled and written to the selected byte lanes.
    - Read: hrdata = mem[index] (full word), driven during this cycle only.
    - A new address phase accepted at the same edge follows the IDLE rules (back-to-back pipelining).
  - ERR1: hreadyout=0, hresp=01; unconditionally go to ERR2.
  - ERR2: hreadyout=1, hresp=01. Memory is untouched. A new address phase may be accepted at this edge, following the IDLE transition rules.
- Byte lanes are little-endian:
  - byte: lane haddr[1:0];
  - half: lanes {haddr[1],0} and {haddr[1],1};
  - word: all 4 lanes.
  - Unselected lanes keep their old value.
- hrdata=0 in every cycle that is not a read DATA completion.
- Read-after-write to the same word in consecutive transfers returns the newly written value: the write commits at the DATA edge, before the read's data phase.
- hreadyout never drops while no transfer is pending.
- hburst, hprot and hmastlock have no effect. SEQ beats are treated exactly like NONSEQ.

Test Plan:
- Reset, then WAIT_STATES=0:
  - write word 0xDEADBEEF to 0x10, read 0x10 -> hrdata=0xDEADBEEF, hresp=00, hreadyout never low.
- WAIT_STATES=3, read 0x10:
  - hreadyout low for exactly 3 cycles, then high with data, hresp=00.
- Byte/half lanes:
  - write word 0x00000000 to 0x20, write byte 0xAA to 0x21, write half 0x1234 to 0x22, read 0x20 -> 0x1234AA00.
- Misaligned word write to 0x02:
  - hresp=01 with hreadyout=0, then hresp=01 with hreadyout=1.
  - A subsequent read of 0x00 returns its prior value.
- Out-of-range read (byte address 0x400, MEM_DEPTH=256):
  - two-cycle ERROR response; hrdata=0.
- Back-to-back:
  - INCR4 SEQ writes 0x1,0x2,0x3,0x4 to 0x40..0x4C with hready held at 1, followed immediately by a read of 0x4C -> 0x4.
  - Asserting hreset during a WAIT -> next cycle hreadyout=1, hresp=00, and memory at the target is unchanged.

Source files
------------

// File: rtl/ahb_slave_memory_responder.sv
// AHB slave responder backed by a word-wide SRAM: programmable wait states,
// little-endian byte-lane writes and the two-cycle ERROR response for illegal accesses.
module ahb_slave_memory_responder #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH      = 256,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned BASE_MASK_BITS = 2
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hselx,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'({ADDR_WIDTH{1'b1}} >> BASE_MASK_BITS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [NUM_LANES-1:0]  be_q, be_d;
    logic                  hreadyout_q, hreadyout_d;
    logic [1:0]            hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic [ADDR_WIDTH-1:0] masked_addr_c;
    logic [IDX_W-1:0]      acc_idx_c;
    logic [NUM_LANES-1:0]  acc_be_c;
    logic                  illegal_c;
    logic                  accept_c;
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  unused_c;

    assign unused_c = ^{hburst, hprot, hmastlock, htrans[0]};

    // Address-phase decode: slave-select bits stripped before range and lane checks.
    always_comb begin
        masked_addr_c = haddr & ADDR_MASK;
        acc_idx_c     = masked_addr_c[IDX_W+1:2];
        case (hsize)
            3'd0:    acc_be_c = NUM_LANES'(1) << masked_addr_c[1:0];
            3'd1:    acc_be_c = masked_addr_c[1] ? NUM_LANES'(4'b1100) : NUM_LANES'(4'b0011);
            default: acc_be_c = '1;
        endcase
        illegal_c = (hsize > 3'd2)
                  || (hsize == 3'd1 && masked_addr_c[0])
                  || (hsize == 3'd2 && masked_addr_c[1:0] != 2'b00)
                  || ((masked_addr_c >> (IDX_W + 2)) != '0);
        accept_c  = hselx && hready && htrans[1]
                  && (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2);
        wr_en_c   = (state_q == ST_DATA) && write_q && !hreset;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        be_d      = be_q;
        rd_word_c = '0;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    idx_d   = acc_idx_c;
                    write_d = hwrite;
                    be_d    = acc_be_c;
                    if (illegal_c) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase

        // A write committing at this edge to the word being read is forwarded into hrdata.
        rd_word_c = mem_q[idx_d];
        for (int b = 0; b < int'(NUM_LANES); b++) begin
            if (wr_en_c && idx_q == idx_d && be_q[b]) rd_word_c[8*b +: 8] = hwdata[8*b +: 8];
        end

        hreadyout_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
        hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? 2'b01 : 2'b00;
        hrdata_d    = (state_d == ST_DATA && !write_d) ? rd_word_c : '0;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            be_q        <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            be_q        <= be_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    // Storage is never reset; only selected lanes are updated.
    always_ff @(posedge hclk) begin
        if (wr_en_c) begin
            for (int b = 0; b < int'(NUM_LANES); b++) begin
                if (be_q[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;

endmodule
